// File: rtl/angle_pkg.sv
// angle_pkg: shared widths and enums for the angle tracker.
// Used by angle_track, its step classifier and its bus interface.
package angle_pkg;

  localparam int ANGLE_W   = 10;
  localparam int ANGLE_MAX = 1023;

  typedef logic [ANGLE_W-1:0] angle_t;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCK
  } state_t;

  typedef enum logic [1:0] {
    HOLD,
    UP,
    DOWN,
    JUMP
  } step_t;

endpackage

// File: rtl/angle_track_if.sv
// angle_track_if: sample stream in, tracking status out.
// master = angle source side, slave = tracker side.
interface angle_track_if
  import angle_pkg::*;
#(
  parameter int PERIOD_W = 16
);

  angle_t                theta_in;
  logic                  theta_valid;
  logic                  seq_dir;
  logic                  wrap;
  logic [PERIOD_W-1:0]   period;
  logic                  period_valid;
  logic                  locked;
  logic                  fault;

  modport master (
    output theta_in,
    output theta_valid,
    input  seq_dir,
    input  wrap,
    input  period,
    input  period_valid,
    input  locked,
    input  fault
  );

  modport slave (
    input  theta_in,
    input  theta_valid,
    output seq_dir,
    output wrap,
    output period,
    output period_valid,
    output locked,
    output fault
  );

endinterface

// File: rtl/angle_step_classify.sv
// angle_step_classify: sorts one angle step into hold/up/down/jump
// and flags steps that cross the 1023/0 seam.
module angle_step_classify
  import angle_pkg::*;
#(
  parameter int MAX_STEP = 8
) (
  input  angle_t i_theta,
  input  angle_t i_last,
  output step_t  o_step,
  output logic   o_wrap
);

  angle_t w_diff;
  int     w_delta;

  assign w_diff  = angle_t'(i_theta - i_last) & angle_t'(ANGLE_MAX);
  assign w_delta = int'($signed(w_diff));

  // classify the signed modular delta
  always_comb begin
    o_step = JUMP;
    unique case (1'b1)
      (w_delta == 0):
        o_step = HOLD;
      (w_delta > 0 && w_delta <= MAX_STEP):
        o_step = UP;
      (w_delta < 0 && w_delta >= -MAX_STEP):
        o_step = DOWN;
      default:
        o_step = JUMP;
    endcase
  end

  assign o_wrap = (o_step == UP   && i_theta < i_last) ||
                  (o_step == DOWN && i_theta > i_last);

endmodule

// File: rtl/angle_track.sv
// angle_track: recovers direction, wraps, period and lock from angles.
// ANGLE_TRACK_TIMEOUT_EN adds the idle-clock timeout back to IDLE.
module angle_track
  import angle_pkg::*;
#(
  parameter int MAX_STEP    = 8,
  parameter int LOCK_CYCLES = 3,
  parameter int PERIOD_W    = 16,
  parameter int TIMEOUT     = 65535
) (
  input logic          clk,
  input logic          RESET_N,
  angle_track_if.slave bus
);

  state_t              r_state, w_state;
  angle_t              r_last, w_last;
  logic                r_dir, w_dir;
  logic                r_wrap, w_wrap;
  logic                r_fault, w_fault;
  logic                r_pvalid, w_pvalid;
  logic                r_locked;
  logic [PERIOD_W-1:0] r_period, w_period;
  logic [PERIOD_W-1:0] r_cnt, w_cnt, w_cnt_inc;
  logic [3:0]          r_wcnt, w_wcnt;
  step_t               w_step;
  logic                w_is_wrap;
  logic                w_rev;
  logic                w_restart;
  logic                w_timeout;

  angle_step_classify #(
    .MAX_STEP (MAX_STEP)
  ) u_cls (
    .i_theta (bus.theta_in),
    .i_last  (r_last),
    .o_step  (w_step),
    .o_wrap  (w_is_wrap)
  );

`ifdef ANGLE_TRACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_idle, w_idle;

  // clocks since the last strobe, saturating at TIMEOUT
  always_comb begin
    w_idle = r_idle;
    if (bus.theta_valid)
      w_idle = '0;
    else if (r_idle != TW'(TIMEOUT))
      w_idle = r_idle + 1'b1;
  end

  assign w_timeout = !bus.theta_valid &&
                     (r_idle == TW'(TIMEOUT - 1));

  // idle counter register
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N)
      r_idle <= '0;
    else
      r_idle <= w_idle;
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout        = 1'b0;
`endif

  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  assign w_rev = (w_step == UP   && !r_dir) ||
                 (w_step == DOWN &&  r_dir);

  // next state, counters and output pulses per sample
  always_comb begin
    w_state   = r_state;
    w_last    = r_last;
    w_dir     = r_dir;
    w_wrap    = 1'b0;
    w_fault   = 1'b0;
    w_period  = r_period;
    w_pvalid  = r_pvalid;
    w_cnt     = r_cnt;
    w_wcnt    = r_wcnt;
    w_restart = 1'b0;
    if (bus.theta_valid) begin
      w_last = bus.theta_in;
      if (r_state == IDLE) begin
        w_state = ACQ;
        w_cnt   = '0;
        w_wcnt  = '0;
      end else begin
        w_cnt = w_cnt_inc;
        unique case (1'b1)
          (w_step == JUMP): begin
            w_fault   = 1'b1;
            w_restart = 1'b1;
          end
          w_rev: begin
            w_dir     = (w_step == UP);
            w_restart = 1'b1;
          end
          default: begin
            if (w_is_wrap) begin
              w_wrap = 1'b1;
              w_cnt  = '0;
              if (r_wcnt != '0) begin
                w_period = w_cnt_inc;
                w_pvalid = 1'b1;
              end
              if (r_state == ACQ) begin
                w_wcnt = r_wcnt + 1'b1;
                if (w_wcnt == 4'(LOCK_CYCLES))
                  w_state = LOCK;
              end
            end
          end
        endcase
        if (w_restart) begin
          w_state  = ACQ;
          w_cnt    = '0;
          w_wcnt   = '0;
          w_pvalid = 1'b0;
        end
      end
    end else if (w_timeout) begin
      w_state  = IDLE;
      w_pvalid = 1'b0;
    end
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= IDLE;
      r_last   <= '0;
      r_dir    <= 1'b1;
      r_wrap   <= 1'b0;
      r_fault  <= 1'b0;
      r_period <= '0;
      r_pvalid <= 1'b0;
      r_locked <= 1'b0;
      r_cnt    <= '0;
      r_wcnt   <= '0;
    end else begin
      r_state  <= w_state;
      r_last   <= w_last;
      r_dir    <= w_dir;
      r_wrap   <= w_wrap;
      r_fault  <= w_fault;
      r_period <= w_period;
      r_pvalid <= w_pvalid;
      r_locked <= (w_state == LOCK);
      r_cnt    <= w_cnt;
      r_wcnt   <= w_wcnt;
    end
  end

  assign bus.seq_dir      = r_dir;
  assign bus.wrap         = r_wrap;
  assign bus.period       = r_period;
  assign bus.period_valid = r_pvalid;
  assign bus.locked       = r_locked;
  assign bus.fault        = r_fault;

endmodule

// File: tb/tb_angle_track.sv
// tb_angle_track: random ramps/walks against a queue-based scoreboard.
// Timeout behaviour follows ANGLE_TRACK_TIMEOUT_EN when defined.
module tb_angle_track;

  localparam int MAX_STEP = 8;
  localparam int LOCK_CYC = 3;
  localparam int TO       = 100;

  typedef struct packed {
    bit        dir;
    bit        wrp;
    bit [15:0] per;
    bit        pv;
    bit        lk;
    bit        flt;
  } exp_t;

  logic clk = 1'b0;
  logic RESET_N;

  angle_track_if bus ();

  angle_track #(
    .MAX_STEP    (MAX_STEP),
    .LOCK_CYCLES (LOCK_CYC),
    .PERIOD_W    (16),
    .TIMEOUT     (TO)
  ) dut (
    .clk     (clk),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];
  int   cur;

  // reference model: 0 idle, 1 acquiring, 2 locked
  int m_state, m_last, m_cnt, m_wraps, m_idle, m_period;
  bit m_dir, m_pv;

  task automatic chk(string nm, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t",
               nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_last   = 0;
    m_cnt    = 0;
    m_wraps  = 0;
    m_idle   = 0;
    m_period = 0;
    m_dir    = 1;
    m_pv     = 0;
  endtask

  task automatic model_restart();
    m_state = 1;
    m_wraps = 0;
    m_cnt   = 0;
    m_pv    = 0;
  endtask

  task automatic model_step(bit v, int th);
    exp_t e;
    bit   w = 0;
    bit   f = 0;
    int   d;
    if (v) begin
      m_idle = 0;
      if (m_state == 0) begin
        m_state = 1;
        m_wraps = 0;
        m_cnt   = 0;
      end else begin
        d = (th - m_last + 1024) % 1024;
        if (d > 511) d -= 1024;
        if (m_cnt < 65535) m_cnt++;
        if (d != 0) begin
          if (d > MAX_STEP || d < -MAX_STEP) begin
            f = 1;
            model_restart();
          end else if ((d > 0) != m_dir) begin
            m_dir = (d > 0);
            model_restart();
          end else if ((d > 0 && th < m_last) ||
                       (d < 0 && th > m_last)) begin
            w = 1;
            if (m_wraps > 0) begin
              m_period = m_cnt;
              m_pv     = 1;
            end
            m_cnt = 0;
            if (m_state == 1) begin
              m_wraps++;
              if (m_wraps == LOCK_CYC) m_state = 2;
            end
          end
        end
      end
      m_last = th;
    end else begin
      m_idle++;
`ifdef ANGLE_TRACK_TIMEOUT_EN
      if (m_idle == TO && m_state != 0) begin
        m_state = 0;
        m_pv    = 0;
      end
`endif
    end
    e.dir = m_dir;
    e.wrp = w;
    e.per = 16'(m_period);
    e.pv  = m_pv;
    e.lk  = (m_state == 2);
    e.flt = f;
    q.push_back(e);
  endtask

  task automatic cyc(bit v, int th);
    @(negedge clk);
    bus.theta_valid = v;
    bus.theta_in    = th[9:0];
    model_step(v, th);
  endtask

  task automatic smp(int th);
    if ($urandom_range(0, 3) == 0)
      cyc(0, int'($urandom_range(0, 1023)));
    cyc(1, th);
    cur = th;
  endtask

  task automatic ramp(int step, int n);
    for (int i = 0; i < n; i++)
      smp(((cur + step) % 1024 + 1024) % 1024);
  endtask

  task automatic chk_reset_vals();
    chk("rst_seq_dir", int'(bus.seq_dir), 1);
    chk("rst_wrap", int'(bus.wrap), 0);
    chk("rst_period", int'(bus.period), 0);
    chk("rst_period_valid", int'(bus.period_valid), 0);
    chk("rst_locked", int'(bus.locked), 0);
    chk("rst_fault", int'(bus.fault), 0);
  endtask

  // monitor: compare registered outputs after each sampled edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("seq_dir", int'(bus.seq_dir), int'(e.dir));
      chk("wrap", int'(bus.wrap), int'(e.wrp));
      chk("period", int'(bus.period), int'(e.per));
      chk("period_valid", int'(bus.period_valid), int'(e.pv));
      chk("locked", int'(bus.locked), int'(e.lk));
      chk("fault", int'(bus.fault), int'(e.flt));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int sgn;
    int r;
    bus.theta_valid = 1'b0;
    bus.theta_in    = '0;
    RESET_N         = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    RESET_N = 1'b1;

    cur = 0;
    smp(0);
    ramp(1, 5 * 1024);

    while (cur != 100) ramp(1, 1);
    smp(400);
    ramp(1, 4 * 1024);

    ramp(-1, 4 * 1024);

    repeat (150) cyc(0, 0);
    ramp(-1, 3 * 1024 + 8);

    ramp(-1, 300);
    @(negedge clk);
    bus.theta_valid = 1'b0;
    RESET_N         = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge clk);
    @(negedge clk);
    RESET_N = 1'b1;
    model_reset();
    smp(512);
    ramp(-4, 5 * 256);

    sgn = -1;
    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2)
        smp((cur + int'($urandom_range(9, 1015))) % 1024);
      else begin
        if (r < 4) sgn = -sgn;
        ramp(sgn * int'($urandom_range(0, MAX_STEP)), 1);
      end
    end

    repeat (3) @(posedge clk);
    #2;
    chk("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/angle_track.md
# angle_track

Receive-side tracker for the 10-bit sawtooth angle stream produced by the angle generator. Samples `theta_in` on a strobe, classifies each step, and recovers phase-sequence direction, wrap events, period in samples and a lock status. Sits downstream of the angle generator and feeds the control logic that needs sequence and frequency information.

## Interface
- `MAX_STEP`, 8: largest |delta| per sample treated as continuous motion (1..511)
- `LOCK_CYCLES`, 3: consecutive clean wraps required to assert lock (1..15)
- `PERIOD_W`, 16: width of period counter/output
- `TIMEOUT`, 65535: clocks without `theta_valid` before dropping to IDLE
- `clk`  in  1  system clock, rising edge
- `RESET_N`  in  1  asynchronous, active-low reset
- `theta_in`  in  10  angle sample, 0..1023
- `theta_valid`  in  1  sample strobe; `theta_in` is sampled when high
- `seq_dir`  out  1  1 = ascending (positive sequence), 0 = descending
- `wrap`  out  1  one-cycle pulse on a wrap-around step
- `period`  out  PERIOD_W  valid samples between last two wraps
- `period_valid`  out  1  `period` holds a complete measurement
- `locked`  out  1  tracker locked
- `fault`  out  1  one-cycle pulse on a discontinuous step

## Operation
- FSM states: IDLE, ACQ, LOCK.
- IDLE: first `theta_valid` stores `last_theta`, no step evaluated, go ACQ with wrap count 0.
- Per valid sample in ACQ/LOCK: `delta = theta_in - last_theta` modulo 1024, interpreted as 10-bit two's complement (-512..511); `last_theta <= theta_in` always.
- delta = 0: hold; no counters touched except sample counter.
- 1 <= delta <= MAX_STEP: ascending step; -MAX_STEP <= delta <= -1: descending step.
- Any other delta: `fault` pulse, go ACQ, clear wrap count, sample counter, `period_valid`.
- Wrap: ascending step with `theta_in < last_theta`, or descending step with `theta_in > last_theta` (e.g. 1023->0 or 0->1023).
- Direction: a non-zero step opposite to `seq_dir` updates `seq_dir` and acts as a fault without the `fault` pulse (restart ACQ, clear counts).
- Sample counter counts valid strobes since last wrap, including the wrapping sample; saturates at 2^PERIOD_W-1.
- On wrap: `wrap` pulse; sample counter reloads to 0. First wrap after entering ACQ only starts measurement; each subsequent wrap loads `period` and sets `period_valid`.
- ACQ: wrap count increments per wrap; reaching LOCK_CYCLES -> LOCK.
- LOCK: stays until fault, direction reversal (-> ACQ) or timeout (-> IDLE).
- Fault and wrap in the same sample: fault wins, no `wrap` pulse.

## Timing
- All outputs registered; response appears the clock after the sampled `theta_valid`.
- `wrap`, `fault`: exactly one cycle high per event.
- `locked` rises the cycle after the LOCK_CYCLES-th wrap; falls the cycle after the terminating event.
- Reset values: `seq_dir`=1, `wrap`=0, `period`=0, `period_valid`=0, `locked`=0, `fault`=0; FSM IDLE, `last_theta`=0.
- Reset asserted mid-operation clears everything immediately (asynchronous); first sample after release is handled as IDLE.
- Idle clock counter resets on each `theta_valid`; reaching TIMEOUT forces IDLE and clears `locked`, `period_valid`.

## Configuration
- `ANGLE_TRACK_TIMEOUT_EN` defined: idle clock counter and TIMEOUT transition present.
- Not defined: counter removed, TIMEOUT parameter ignored; tracker holds state indefinitely without samples.

## Structure
- Shared package `angle_pkg`: `ANGLE_W`=10, `ANGLE_MAX`=1023, FSM state typedef (IDLE, ACQ, LOCK), step-class typedef (HOLD, UP, DOWN, JUMP).
- One sub-module: `angle_step_classify` (combinational: `theta_in`, `last_theta`, MAX_STEP -> step class, wrap flag).

## Test plan
- Ascending ramp, +1 per strobe from 0, 5 cycles -> `wrap` at each 1023->0, `locked` after 3rd wrap, `period`=1024, `period_valid` after 2nd wrap.
- Descending ramp, -4 per strobe from 512 -> `seq_dir`=0, `wrap` on 0->1020, `period`=256, `locked` after 3 wraps.
- While locked, inject jump 100->400 -> `fault` one cycle, `locked`=0 next cycle, `period_valid`=0, relock after 3 clean wraps.
- While locked ascending, reverse to -1 steps -> no `fault`, `seq_dir`=0, `locked` drops, relocks after 3 wraps.
- With `ANGLE_TRACK_TIMEOUT_EN`, TIMEOUT=100, stop strobes while locked -> `locked`=0 exactly 100 clocks after last strobe; without macro stays 1.
- Assert `RESET_N` low mid-ramp -> all outputs to reset values asynchronously; restart -> first sample ignored for step, lock reacquired.
